// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. It divides the system clock into
//   pixel ticks and walks a (hcount, vcount) raster position. From the new
//   position it decodes sync, display-enable and blanking. It also emits
//   pixel/line/frame strobes for the renderer and the video output stage.
//
//   Ports
//     clk          system clock; all logic is on the rising edge
//     rst          synchronous reset, active-high
//     hcount       horizontal pixel position, 0..H_TOTAL-1
//     vcount       line position, 0..V_TOTAL-1
//     hsync        horizontal sync, active level given by H_POL
//     vsync        vertical sync, active level given by V_POL
//     display      visible-area flag
//     vblank       vertical blanking flag (vcount >= V_ACTIVE)
//     pix_ce       one-clk pulse when a new pixel position is presented
//     line_start   one-clk pulse when hcount becomes 0
//     frame_start  one-clk pulse when the position becomes (0,0)
//
//   All outputs come straight from flops.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int CLK_DIV  = 1,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          display,
  output logic          vblank,
  output logic          pix_ce,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

  // Window bounds are one bit wider than the counters, so an end bound equal
  // to the total count (zero back porch) still compares correctly.
  localparam logic [HW:0] H_DISP_END  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] H_SYNC_BEG  = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] H_SYNC_END  = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] V_DISP_END  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] V_SYNC_BEG  = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] V_SYNC_END  = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          display_q, display_d;
  logic          vblank_q, vblank_d;
  logic          pix_ce_q, pix_ce_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          tick;
  logic [HW:0]   h_ext;
  logic [VW:0]   v_ext;

  // Next-state logic. Between ticks every level output holds its value, and
  // strobes drop to 0. On a tick the position advances. Every decoded output
  // is then computed from the new position, so it lines up with hcount/vcount
  // in the same cycle.
  always_comb begin
    tick          = (div_q == DIV_LAST);
    div_d         = tick ? '0 : div_q + 1'b1;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    display_d     = display_q;
    vblank_d      = vblank_q;
    pix_ce_d      = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    h_ext         = '0;
    v_ext         = '0;

    if (tick) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end

      h_ext = {1'b0, hcount_d};
      v_ext = {1'b0, vcount_d};

      // A zero-width sync gives begin == end, so the window is empty.
      hsync_d       = ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END)) ? H_POL : ~H_POL;
      vsync_d       = ((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END)) ? V_POL : ~V_POL;
      display_d     = (h_ext < H_DISP_END) && (v_ext < V_DISP_END);
      vblank_d      = (v_ext >= V_DISP_END);
      pix_ce_d      = 1'b1;
      line_start_d  = (hcount_d == '0);
      frame_start_d = (hcount_d == '0) && (vcount_d == '0);
    end
  end

  // State register. Reset parks the raster on the last position of the frame,
  // so the first tick after release lands on (0,0) and raises frame_start.
  // Reset also overrides any tick that is pending, so no partial strobe escapes.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      display_q     <= 1'b0;
      vblank_q      <= 1'b1;
      pix_ce_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_q     <= display_d;
      vblank_q      <= vblank_d;
      pix_ce_q      <= pix_ce_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display     = display_q;
  assign vblank      = vblank_q;
  assign pix_ce      = pix_ce_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Drives four vga_timing_gen instances from a shared clock and reset:
//     d : default 800x600 timing
//     s : CLK_DIV=4, H 8/2/2/2, V 4/1/1/1
//     n : active-low syncs, H 6/1/2/0, V 3/0/2/1 (zero back/front porch)
//     z : CLK_DIV=3, H 5/0/0/2, V 3/1/0/1 (zero sync widths)
//   A reference model computes each instance's outputs from the number of
//   clock edges since reset release.
module tb_vga_timing_gen;

  typedef struct packed {
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic disp;
    logic vbl;
    logic pce;
    logic ls;
    logic fs;
  } obs_t;

  typedef struct {
    int   ha, hf, hsw, hb, va, vf, vsw, vb, div;
    logic hp, vp;
  } cfg_t;

  typedef struct {
    int   rst_cyc;
    int   run_cyc;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k = 0;
  int   tests = 0;
  int   failed = 0;
  cfg_t cfgs[4];

  logic [10:0] d_h; logic [9:0] d_v;
  logic d_hs, d_vs, d_de, d_vb, d_ce, d_ls, d_fs;
  logic [3:0] s_h; logic [2:0] s_v;
  logic s_hs, s_vs, s_de, s_vb, s_ce, s_ls, s_fs;
  logic [3:0] n_h; logic [2:0] n_v;
  logic n_hs, n_vs, n_de, n_vb, n_ce, n_ls, n_fs;
  logic [2:0] z_h; logic [2:0] z_v;
  logic z_hs, z_vs, z_de, z_vb, z_ce, z_ls, z_fs;

  always #5 clk = ~clk;

  // Edges since the last edge that saw reset asserted.
  always @(posedge clk) k <= rst ? 0 : k + 1;

  vga_timing_gen u_d (
    .clk(clk), .rst(rst), .hcount(d_h), .vcount(d_v), .hsync(d_hs), .vsync(d_vs),
    .display(d_de), .vblank(d_vb), .pix_ce(d_ce), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(4), .HW(4), .VW(3)
  ) u_s (
    .clk(clk), .rst(rst), .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs),
    .display(s_de), .vblank(s_vb), .pix_ce(s_ce), .line_start(s_ls), .frame_start(s_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(0), .V_ACTIVE(3), .V_FP(0), .V_SYNC(2),
    .V_BP(1), .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(1), .HW(4), .VW(3)
  ) u_n (
    .clk(clk), .rst(rst), .hcount(n_h), .vcount(n_v), .hsync(n_hs), .vsync(n_vs),
    .display(n_de), .vblank(n_vb), .pix_ce(n_ce), .line_start(n_ls), .frame_start(n_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(5), .H_FP(0), .H_SYNC(0), .H_BP(2), .V_ACTIVE(3), .V_FP(1), .V_SYNC(0),
    .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(3), .HW(3), .VW(3)
  ) u_z (
    .clk(clk), .rst(rst), .hcount(z_h), .vcount(z_v), .hsync(z_hs), .vsync(z_vs),
    .display(z_de), .vblank(z_vb), .pix_ce(z_ce), .line_start(z_ls), .frame_start(z_fs)
  );

  function automatic obs_t mk(int h, int v, logic hs, logic vs, logic disp, logic vbl,
                              logic pce, logic ls, logic fs);
    obs_t o;
    o.h = h; o.v = v; o.hs = hs; o.vs = vs; o.disp = disp; o.vbl = vbl;
    o.pce = pce; o.ls = ls; o.fs = fs;
    return o;
  endfunction

  // Reference model. After e edges out of reset, e/div pixel ticks have
  // occurred. Tick n (n >= 1) shows raster index n-1, taken modulo the
  // frame size.
  function automatic obs_t model(cfg_t c, int e);
    obs_t o;
    int ht, vt, t, p, h, v;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    t  = e / c.div;
    if (t == 0) begin
      o = mk(ht - 1, vt - 1, ~c.hp, ~c.vp, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end else begin
      p = (t - 1) % (ht * vt);
      h = p % ht;
      v = p / ht;
      o.h    = h;
      o.v    = v;
      o.hs   = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) ? c.hp : ~c.hp;
      o.vs   = (v >= c.va + c.vf && v < c.va + c.vf + c.vsw) ? c.vp : ~c.vp;
      o.disp = (h < c.ha) && (v < c.va);
      o.vbl  = (v >= c.va);
      o.pce  = (e % c.div == 0);
      o.ls   = o.pce && (h == 0);
      o.fs   = o.pce && (p == 0);
    end
    return o;
  endfunction

  function automatic obs_t act(int idx);
    case (idx)
      0:       return mk(int'(d_h), int'(d_v), d_hs, d_vs, d_de, d_vb, d_ce, d_ls, d_fs);
      1:       return mk(int'(s_h), int'(s_v), s_hs, s_vs, s_de, s_vb, s_ce, s_ls, s_fs);
      2:       return mk(int'(n_h), int'(n_v), n_hs, n_vs, n_de, n_vb, n_ce, n_ls, n_fs);
      default: return mk(int'(z_h), int'(z_v), z_hs, z_vs, z_de, z_vb, z_ce, z_ls, z_fs);
    endcase
  endfunction

  task automatic checkOutput(input string name, input obs_t got, input obs_t want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("[TB] FAIL %s k=%0d: got h=%0d v=%0d hs=%b vs=%b de=%b vb=%b ce=%b ls=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b de=%b vb=%b ce=%b ls=%b fs=%b",
               name, k, got.h, got.v, got.hs, got.vs, got.disp, got.vbl, got.pce, got.ls, got.fs,
               want.h, want.v, want.hs, want.vs, want.disp, want.vbl, want.pce, want.ls, want.fs);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Advance one clock. Sample on the falling edge, then compare every instance
  // with the model.
  task automatic step();
    @(negedge clk);
    checkOutput("model_d", act(0), model(cfgs[0], k));
    checkOutput("model_s", act(1), model(cfgs[1], k));
    checkOutput("model_n", act(2), model(cfgs[2], k));
    checkOutput("model_z", act(3), model(cfgs[3], k));
  endtask

  task automatic applyStimulus(input int rst_cyc, input int run_cyc);
    rst = 1'b1;
    repeat (rst_cyc) step();
    rst = 1'b0;
    repeat (run_cyc) step();
  endtask

  initial begin
    vec_t vecs[11];
    int   first_fs, second_fs, ce_cnt, prev_h;

    cfgs[0] = '{ha:800, hf:40, hsw:128, hb:88, va:600, vf:1, vsw:4, vb:23, div:1, hp:1'b1, vp:1'b1};
    cfgs[1] = '{ha:8, hf:2, hsw:2, hb:2, va:4, vf:1, vsw:1, vb:1, div:4, hp:1'b1, vp:1'b1};
    cfgs[2] = '{ha:6, hf:1, hsw:2, hb:0, va:3, vf:0, vsw:2, vb:1, div:1, hp:1'b0, vp:1'b0};
    cfgs[3] = '{ha:5, hf:0, hsw:0, hb:2, va:3, vf:1, vsw:0, vb:1, div:3, hp:1'b1, vp:1'b1};

    // Directed line walk on the default instance. Each row restarts from reset.
    vecs[0]  = '{3, 0,    mk(1055, 627, 0, 0, 0, 1, 0, 0, 0)};
    vecs[1]  = '{3, 1,    mk(0,    0,   0, 0, 1, 0, 1, 1, 1)};
    vecs[2]  = '{2, 2,    mk(1,    0,   0, 0, 1, 0, 1, 0, 0)};
    vecs[3]  = '{2, 800,  mk(799,  0,   0, 0, 1, 0, 1, 0, 0)};
    vecs[4]  = '{2, 801,  mk(800,  0,   0, 0, 0, 0, 1, 0, 0)};
    vecs[5]  = '{2, 840,  mk(839,  0,   0, 0, 0, 0, 1, 0, 0)};
    vecs[6]  = '{2, 841,  mk(840,  0,   1, 0, 0, 0, 1, 0, 0)};
    vecs[7]  = '{2, 968,  mk(967,  0,   1, 0, 0, 0, 1, 0, 0)};
    vecs[8]  = '{2, 969,  mk(968,  0,   0, 0, 0, 0, 1, 0, 0)};
    vecs[9]  = '{2, 1056, mk(1055, 0,   0, 0, 0, 0, 1, 0, 0)};
    vecs[10] = '{2, 1057, mk(0,    1,   0, 0, 1, 0, 1, 1, 0)};

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rst_cyc, vecs[i].run_cyc);
      checkOutput($sformatf("vec%0d", i), act(0), vecs[i].exp);
    end

    // Divided instance: pix_ce cadence, hold between ticks, frame period.
    applyStimulus(2, 0);
    first_fs = -1; second_fs = -1; ce_cnt = 0; prev_h = int'(s_h);
    for (int i = 1; i <= 800; i++) begin
      step();
      if (s_ce) ce_cnt++;
      else      checkInt("s_hold", int'(s_h), prev_h);
      if (s_fs) begin
        if (first_fs < 0)       first_fs = i;
        else if (second_fs < 0) second_fs = i;
      end
      prev_h = int'(s_h);
    end
    checkInt("s_ce_count", ce_cnt, 200);
    checkInt("s_first_frame", first_fs, 4);
    checkInt("s_frame_period", second_fs - first_fs, 392);

    // Reset pulse mid-frame, while the divider is part-way through its count.
    applyStimulus(2, 137);
    rst = 1'b1;
    step();
    checkOutput("s_rst_mid", act(1), mk(13, 6, 0, 0, 0, 1, 0, 0, 0));
    rst = 1'b0;
    repeat (3) step();
    checkInt("s_no_ce_after_rst", int'(s_ce), 0);
    step();
    checkOutput("s_first_tick", act(1), mk(0, 0, 0, 0, 1, 0, 1, 1, 1));

    // Active-low syncs with zero back porch.
    applyStimulus(2, 0);
    checkOutput("n_reset", act(2), mk(8, 5, 1, 1, 0, 1, 0, 0, 0));
    applyStimulus(2, 7);
    checkOutput("n_pre_sync", act(2), mk(6, 0, 1, 1, 0, 0, 1, 0, 0));
    step();
    checkOutput("n_sync_beg", act(2), mk(7, 0, 0, 1, 0, 0, 1, 0, 0));
    step();
    checkOutput("n_sync_end", act(2), mk(8, 0, 0, 1, 0, 0, 1, 0, 0));
    step();
    checkOutput("n_wrap", act(2), mk(0, 1, 1, 1, 1, 0, 1, 1, 0));
    repeat (18) step();
    checkOutput("n_vsync", act(2), mk(0, 3, 1, 0, 0, 1, 1, 1, 0));

    // Free run with random reset pulses; the model checks every cycle.
    rst = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 599) == 0) rst = 1'b1;
      else if (rst && $urandom_range(0, 1) == 1) rst = 1'b0;
      step();
    end
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
